// File: rtl/memory_bus_port_pkg.sv
// Shared definitions for the memory bus port.
//   state_e   : bus-port FSM states (IDLE, REQUEST, DONE)
//   SIZE_*    : access-size encodings carried on mem_size (2'b11 is handled as word)
package memory_bus_port_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/memory_bus_port_load_align.sv
// load_align: combinational load-data alignment.
//   rdata    in  32  raw word from the bus
//   addr_lo  in  2   byte offset of the access within the word
//   size     in  2   access size (byte/half/word, 11 = word)
//   sign_ext in  1   sign-extend (1) or zero-extend (0)
//   data     out 32  shifted, truncated and extended load value
module load_align
   import memory_bus_port_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Addressed byte moves down to lane 0; a misaligned half at offset 3
   // simply sees zeros shifted into its upper byte.
   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      data = shifted;
      case (size)
         SIZE_BYTE: data = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
         SIZE_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default:   data = shifted;
      endcase
   end

endmodule

// File: rtl/memory_bus_port.sv
// memory_bus_port: bridges the memory pipeline stage to a valid/ready bus.
//   clk, reset_n         clock, asynchronous active-low reset
//   mem_address      in  byte address from the memory stage
//   mem_store_data   in  right-aligned store data
//   mem_size         in  access size (00 byte, 01 half, 10/11 word)
//   mem_signed       in  sign-extend load result
//   mem_load/store   in  access request, held stable while mem_busy=1
//   mem_load_data    out registered, aligned, extended load result
//   mem_busy         out stall request to the hazard unit
//   bus_address      out word address (bits [1:0] = 0)
//   bus_write_data   out lane-replicated store data
//   bus_strobe       out byte-lane enables
//   bus_write        out 1 = write, 0 = read
//   bus_valid        out request valid
//   bus_ready        in  responder accepts/completes the beat
//   bus_read_data    in  read word, valid on bus_valid && bus_ready
module memory_bus_port
   import memory_bus_port_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_store_data,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic        mem_load,
   input  logic        mem_store,
   output logic [31:0] mem_load_data,
   output logic        mem_busy,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_strobe,
   output logic        bus_write,
   output logic        bus_valid,
   input  logic        bus_ready,
   input  logic [31:0] bus_read_data
);

   state_e      state;
   logic [1:0]  size_q;
   logic [1:0]  addr_lo_q;
   logic        signed_q;
   logic [31:0] load_q;
   logic [31:0] aligned;

   logic        req;
   logic        is_write;
   logic [3:0]  strobe_c;
   logic [31:0] wdata_c;

   assign req      = mem_load | mem_store;
   // Load wins when both request lines are raised.
   assign is_write = mem_store & ~mem_load;

   always_comb begin
      strobe_c = 4'b1111;
      wdata_c  = mem_store_data;
      case (mem_size)
         SIZE_BYTE: begin
            strobe_c = 4'b0001 << mem_address[1:0];
            wdata_c  = {4{mem_store_data[7:0]}};
         end
         SIZE_HALF: begin
            strobe_c = 4'b0011 << {mem_address[1], 1'b0};
            wdata_c  = {2{mem_store_data[15:0]}};
         end
         default: begin
            strobe_c = 4'b1111;
            wdata_c  = mem_store_data;
         end
      endcase
   end

   load_align u_load_align (
      .rdata    (bus_read_data),
      .addr_lo  (addr_lo_q),
      .size     (size_q),
      .sign_ext (signed_q),
      .data     (aligned)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         bus_valid      <= 1'b0;
         bus_write      <= 1'b0;
         bus_strobe     <= 4'b0000;
         bus_address    <= 32'h0;
         bus_write_data <= 32'h0;
         size_q         <= SIZE_BYTE;
         addr_lo_q      <= 2'b00;
         signed_q       <= 1'b0;
         load_q         <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  bus_address    <= {mem_address[31:2], 2'b00};
                  bus_write      <= is_write;
                  bus_strobe     <= is_write ? strobe_c : 4'b1111;
                  bus_write_data <= is_write ? wdata_c : 32'h0;
                  size_q         <= mem_size;
                  addr_lo_q      <= mem_address[1:0];
                  signed_q       <= mem_signed;
                  bus_valid      <= 1'b1;
                  state          <= REQUEST;
               end
            end
            REQUEST: begin
               // Bus outputs stay frozen until the responder takes the beat,
               // regardless of what the pipeline does with its request lines.
               if (bus_ready) begin
                  if (!bus_write) load_q <= aligned;
                  bus_valid <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Busy drops in DONE so the pipeline advances exactly one cycle.
   assign mem_busy      = req && (state != DONE);
   assign mem_load_data = load_q;

endmodule
